// File: rtl/alu_issue_if.sv
// alu_issue instruction handshake and ALU-side bus.
// The master side issues instructions and provides the ALU result.
interface alu_issue_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [3:0]  alu_opcode;
  logic        alu_ar_flag;
  logic [15:0] alu_src1;
  logic [15:0] alu_src2;
  logic        alu_out_en;
  logic [15:0] alu_result;

  modport master (
    output instr_valid,
    output instr,
    output alu_result,
    input  instr_ready,
    input  alu_opcode,
    input  alu_ar_flag,
    input  alu_src1,
    input  alu_src2,
    input  alu_out_en
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  alu_result,
    output instr_ready,
    output alu_opcode,
    output alu_ar_flag,
    output alu_src1,
    output alu_src2,
    output alu_out_en
  );
endinterface

// File: rtl/alu_issue.sv
// tiny16 issue/writeback stage in front of the ALU.
// Three-cycle IDLE/READ/EXEC sequence per instruction.
module alu_issue (
  input  logic        clk,
  input  logic        rst,
  alu_issue_if.slave  bus,
  output logic        div0,
  output logic [15:0] retired,
  input  logic [3:0]  dbg_addr,
  output logic [15:0] dbg_data
);

  typedef enum logic [1:0] {
    IDLE,
    READ,
    EXEC
  } state_t;

  state_t state;
  state_t state_nx;

  logic [15:0] ir;
  logic [15:0] rf [16];

  logic [3:0]  op;
  logic [3:0]  rd;
  logic [3:0]  rs;
  logic [3:0]  rt;
  logic [15:0] rs_val;
  logic [15:0] rt_val;
  logic [15:0] imm;

  logic        is_alu;
  logic        is_cmp;
  logic        is_ldi;
  logic        is_mov;
  logic        is_div;
  logic        dz;

  logic [3:0]  opc_nx;
  logic        ar_nx;
  logic [3:0]  opc_q;
  logic        ar_q;
  logic [15:0] src1_q;
  logic [15:0] src2_q;

  logic        out_en;
  logic        we;
  logic [15:0] wdata;

  assign op = ir[15:12];
  assign rd = ir[11:8];
  assign rs = ir[7:4];
  assign rt = ir[3:0];
  assign imm = {{8{ir[7]}}, ir[7:0]};

  assign rs_val = (rs == 4'd0) ? '0 : rf[rs];
  assign rt_val = (rt == 4'd0) ? '0 : rf[rt];

  // ALU ops span ADD..SHR plus the two arithmetic shifts
  assign is_alu = (op >= 4'h3) && (op <= 4'hD);
  assign is_cmp = (op == 4'hE);
  assign is_ldi = (op == 4'h1);
  assign is_mov = (op == 4'h2);
  assign is_div = (op == 4'h6);

  always_comb begin
    opc_nx = '0;
    ar_nx  = 1'b0;
    unique case (1'b1)
      (op >= 4'h3 && op <= 4'hB): opc_nx = op;
      (op == 4'hC): begin
        opc_nx = 4'hA;
        ar_nx  = 1'b1;
      end
      (op == 4'hD): begin
        opc_nx = 4'hB;
        ar_nx  = 1'b1;
      end
      is_cmp: opc_nx = 4'h4;
      default: ;
    endcase
  end

  always_comb begin
    state_nx = state;
    out_en   = 1'b0;
    we       = 1'b0;
    wdata    = bus.alu_result;
    unique case (state)
      IDLE: begin
        if (bus.instr_valid) state_nx = READ;
      end
      READ: state_nx = EXEC;
      EXEC: begin
        state_nx = IDLE;
        if ((is_alu || is_cmp) && !dz) out_en = 1'b1;
        if (is_alu && !dz) we = 1'b1;
        if (is_ldi) begin
          we    = 1'b1;
          wdata = imm;
        end
        if (is_mov) begin
          we    = 1'b1;
          wdata = src1_q;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ir      <= '0;
      opc_q   <= '0;
      ar_q    <= 1'b0;
      src1_q  <= '0;
      src2_q  <= '0;
      dz      <= 1'b0;
      div0    <= 1'b0;
      retired <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && bus.instr_valid) ir <= bus.instr;
      if (state == READ) begin
        src1_q <= rs_val;
        src2_q <= rt_val;
        opc_q  <= opc_nx;
        ar_q   <= ar_nx;
        dz     <= is_div && (rt_val == 16'd0);
      end
      if (state == EXEC) begin
        retired <= retired + 16'd1;
        if (dz) div0 <= 1'b1;
      end
    end
  end

  // r0 is never written, so it stays at its reset value of zero
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) rf[i] <= '0;
    end else if (we && rd != 4'd0) begin
      rf[rd] <= wdata;
    end
  end

  assign bus.instr_ready = (state == IDLE);
  assign bus.alu_opcode  = opc_q;
  assign bus.alu_ar_flag = ar_q;
  assign bus.alu_src1    = src1_q;
  assign bus.alu_src2    = src2_q;
  assign bus.alu_out_en  = out_en;

  assign dbg_data = (dbg_addr == 4'd0) ? '0 : rf[dbg_addr];

endmodule

// File: tb/tb_alu_issue.sv
// Randomized scoreboard bench for alu_issue with a behavioural ALU
// and an architectural reference model of the register file.
module tb_alu_issue;

  logic        clk;
  logic        rst;
  logic        div0;
  logic [15:0] retired;
  logic [3:0]  dbg_addr;
  logic [15:0] dbg_data;

  alu_issue_if bus ();

  alu_issue dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus),
    .div0     (div0),
    .retired  (retired),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int failed = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // behavioural ALU: {carry, result}
  function automatic logic [16:0] alu_fn(input logic [3:0] o,
      input logic ar, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] r;
    logic [31:0] m;
    r = '0;
    case (o)
      4'h3: r = {1'b0, a} + {1'b0, b};
      4'h4: r = {1'b0, a} - {1'b0, b};
      4'h5: begin
        m = a * b;
        r = {1'b0, m[15:0]};
      end
      4'h6: r = (b == 0) ? '0 : {1'b0, a / b};
      4'h7: r = {1'b0, a & b};
      4'h8: r = {1'b0, a | b};
      4'h9: r = {1'b0, a ^ b};
      4'hA: r = {1'b0, a << b[3:0]};
      4'hB: r = ar ? {1'b0, 16'($signed(a) >>> b[3:0])}
                   : {1'b0, a >> b[3:0]};
      default: r = '0;
    endcase
    return r;
  endfunction

  logic [16:0] alu_full;
  always_comb begin
    alu_full = alu_fn(bus.alu_opcode, bus.alu_ar_flag,
                      bus.alu_src1, bus.alu_src2);
    bus.alu_result = alu_full[15:0];
  end

  logic cflag = 1'b0;
  logic zflag = 1'b0;
  always @(posedge clk) begin
    if (bus.alu_out_en) begin
      cflag <= alu_full[16];
      zflag <= (alu_full[15:0] == 16'd0);
    end
  end

  typedef struct {
    logic [3:0]  rd;
    logic [15:0] val;
    logic        d0;
    logic [15:0] ret;
    logic        oe;
    logic [3:0]  opc;
    logic        ar;
  } exp_t;

  exp_t q[$];
  int   mreg[16];
  bit   mdiv0;
  int   mret;

  function automatic void model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 0;
    mdiv0 = 0;
    mret  = 0;
  endfunction

  // architectural effect of one instruction, in plain integer arithmetic
  function automatic void model(input logic [15:0] w);
    int op, rd, rs, rt, a, b, v, sa, sh;
    bit wr, oe, ar;
    int opc;
    exp_t e;
    op = int'(w[15:12]);
    rd = int'(w[11:8]);
    rs = int'(w[7:4]);
    rt = int'(w[3:0]);
    a  = mreg[rs];
    b  = mreg[rt];
    sh = b % 16;
    sa = (a >= 32768) ? a - 65536 : a;
    v = 0; wr = 0; oe = 0; ar = 0; opc = 0;
    case (op)
      1: begin
        v  = int'(w[7:0]);
        if (v >= 128) v = v + 65280;
        wr = 1;
      end
      2: begin v = a; wr = 1; end
      3, 4, 5, 7, 8, 9, 10, 11: begin
        oe = 1; opc = op; wr = 1;
        case (op)
          3: v = (a + b) % 65536;
          4: v = (a - b + 65536) % 65536;
          5: v = int'((longint'(a) * longint'(b)) % 65536);
          7: v = a & b;
          8: v = a | b;
          9: v = a ^ b;
          10: v = (a * (1 << sh)) % 65536;
          default: v = a / (1 << sh);
        endcase
      end
      6: begin
        if (b == 0) mdiv0 = 1;
        else begin
          oe = 1; opc = 6; wr = 1; v = a / b;
        end
      end
      12: begin
        oe = 1; opc = 10; ar = 1; wr = 1;
        v = (a * (1 << sh)) % 65536;
      end
      13: begin
        oe = 1; opc = 11; ar = 1; wr = 1;
        v = (sa >>> sh) & 65535;
      end
      14: begin oe = 1; opc = 4; end
      default: ;
    endcase
    if (wr && rd != 0) mreg[rd] = v;
    mret = (mret + 1) % 65536;
    e.rd  = w[11:8];
    e.val = 16'(mreg[rd]);
    e.d0  = mdiv0;
    e.ret = 16'(mret);
    e.oe  = oe;
    e.opc = 4'(opc);
    e.ar  = ar;
    q.push_back(e);
  endfunction

  // monitor: each retirement pops one expectation
  initial begin
    logic [15:0] last;
    int pulses;
    logic [3:0] so;
    logic sar;
    exp_t e;
    last = '0; pulses = 0; so = '0; sar = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        last = '0;
        pulses = 0;
        continue;
      end
      if (bus.alu_out_en) begin
        pulses++;
        so  = bus.alu_opcode;
        sar = bus.alu_ar_flag;
      end
      if (retired != last) begin
        last = retired;
        if (q.size() == 0) begin
          chk("unexpected_retire", 32'(retired), 32'hFFFF_FFFF);
        end else begin
          e = q.pop_front();
          dbg_addr = e.rd;
          #1;
          chk("rd_value", 32'(dbg_data), 32'(e.val));
          chk("div0", 32'(div0), 32'(e.d0));
          chk("retired", 32'(retired), 32'(e.ret));
          chk("out_en_pulses", 32'(pulses), 32'(e.oe));
          if (e.oe) begin
            chk("alu_opcode", 32'(so), 32'(e.opc));
            chk("alu_ar_flag", 32'(sar), 32'(e.ar));
          end
        end
        pulses = 0;
      end
    end
  end

  int  prev_acc = -100;
  bit  prev_held = 0;

  task automatic issue(input logic [15:0] w, input bit hold);
    int n;
    n = 0;
    @(negedge clk);
    bus.instr = w;
    bus.instr_valid = 1'b1;
    while (!bus.instr_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      chk("ready_timeout", 32'(n), 32'd0);
    end else begin
      @(posedge clk);
      model(w);
      #1;
      if (prev_held) chk("accept_gap", 32'(cyc - prev_acc), 32'd3);
      prev_acc  = cyc;
      prev_held = hold;
      bus.instr_valid = hold;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("drain_timeout", 32'(q.size()), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [15:0] w;
    rst = 1'b1;
    bus.instr_valid = 1'b0;
    bus.instr = '0;
    dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_retired", 32'(retired), 32'd0);
    chk("rst_div0", 32'(div0), 32'd0);
    chk("rst_out_en", 32'(bus.alu_out_en), 32'd0);
    chk("rst_opcode", 32'({bus.alu_ar_flag, bus.alu_opcode}), 32'd0);
    chk("rst_srcs", {bus.alu_src1, bus.alu_src2}, 32'd0);
    rst = 1'b0;

    issue(16'h1105, 1'b1);
    issue(16'h12FE, 1'b0);
    wait_idle();
    dbg_addr = 4'd2; #1;
    chk("ldi_r2", 32'(dbg_data), 32'hFFFE);
    chk("retired_2", 32'(retired), 32'd2);

    issue(16'h3312, 1'b0);
    wait_idle();
    dbg_addr = 4'd3; #1;
    chk("add_r3", 32'(dbg_data), 32'h0003);
    chk("add_carry", 32'(cflag), 32'd1);

    issue(16'hE011, 1'b0);
    wait_idle();
    chk("cmp_zero", 32'(zflag), 32'd1);
    issue(16'h107F, 1'b0);
    wait_idle();
    dbg_addr = 4'd0; #1;
    chk("r0_zero", 32'(dbg_data), 32'd0);

    issue(16'h6410, 1'b0);
    wait_idle();
    chk("div0_set", 32'(div0), 32'd1);
    issue(16'h6421, 1'b0);
    wait_idle();
    dbg_addr = 4'd4; #1;
    chk("div_r4", 32'(dbg_data), 32'h3332);
    chk("div0_sticky", 32'(div0), 32'd1);

    issue(16'h1601, 1'b0);
    issue(16'hD526, 1'b0);
    wait_idle();
    dbg_addr = 4'd5; #1;
    chk("asr_r5", 32'(dbg_data), 32'hFFFF);

    for (int i = 0; i < 8; i++) issue(16'hD526, i != 7);
    wait_idle();

    for (int i = 0; i < 200; i++) begin
      w = 16'($urandom);
      issue(w, ($urandom_range(0, 3) != 0) && i != 199);
      if (!bus.instr_valid) repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    prev_held = 0;
    wait_idle();
    for (int i = 0; i < 16; i++) begin
      dbg_addr = 4'(i); #1;
      chk("rf_sweep", 32'(dbg_data), 32'(mreg[i]));
    end

    issue(16'h3711, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    q.delete();
    model_reset();
    #1;
    dbg_addr = 4'd7; #1;
    chk("rst_mid_r7", 32'(dbg_data), 32'd0);
    chk("rst_mid_retired", 32'(retired), 32'd0);
    chk("rst_mid_ready", 32'(bus.instr_ready), 32'd1);
    chk("rst_mid_out_en", 32'(bus.alu_out_en), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    issue(16'h1183, 1'b0);
    issue(16'h3711, 1'b0);
    wait_idle();
    dbg_addr = 4'd7; #1;
    chk("post_rst_add", 32'(dbg_data), 32'hFF06);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
